// File: rtl/dmem_responder.sv
// Handshaked 4 KB data-memory slave for the MEM-stage load/store port.
// One transaction in flight; programmable wait states before the array access.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);
    // Both channels are valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; the sender holds valid and its payload stable until then.

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_ready_q;
    logic              resp_valid_q;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       old_word;
    logic [31:0]       merged_word;

    assign old_word = mem[addr_q];

    // Loads see the old word unchanged; stores replace only the enabled bytes.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (we_q && be_q[i]) begin
                merged_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                rdata_d = merged_word;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= (state_d == S_IDLE);
            resp_valid_q <= (state_d == S_RESP);
        end
    end

    // The array is not reset; a reset edge in ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_ACCESS && we_q) begin
            mem[addr_q] <= merged_word;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign busy       = (state_q != S_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of load/store vectors plus multi-cycle corner sequences,
// responses checked by a scoreboard queue against a default build and a zero-wait build.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready_a, resp_valid_a, busy_a;
    logic [31:0] resp_rdata_a;
    logic [1:0]  state_a;
    logic        req_ready_b, resp_valid_b, busy_b;
    logic [31:0] resp_rdata_b;
    logic [1:0]  state_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc  = 0;
    int prev_acc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp0_q[$];
    logic [31:0] model_mem [1024];

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[11];

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a),
        .busy(busy_a), .state_dbg(state_a)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b),
        .busy(busy_b), .state_dbg(state_b)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endfunction

    // Scoreboard: each response handshake pops the oldest expected word
    always @(negedge clk) begin
        if (!rst && resp_valid_a && resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_a_unexpected: got=%h want=none", resp_rdata_a);
            end else begin
                check("resp_a_rdata", resp_rdata_a, exp_q.pop_front());
            end
        end
        if (!rst && resp_valid_b && resp_ready) begin
            if (exp0_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_b_unexpected: got=%h want=none", resp_rdata_b);
            end else begin
                check("resp_b_rdata", resp_rdata_b, exp0_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input bit sel, input logic we, input logic [9:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] exp, input bit push);
        int n;
        logic [31:0] merged;
        n = 0;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        while (((sel ? req_ready_b : req_ready_a) == 1'b0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        if (push) begin
            if (sel) begin
                exp0_q.push_back(exp);
            end else begin
                exp_q.push_back(exp);
                merged = model_mem[addr];
                for (int i = 0; i < 4; i++) begin
                    if (we && be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
                end
                model_mem[addr] = merged;
            end
        end
        tick();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic wait_resp(input bit sel, input int lat);
        int n;
        n = 0;
        while (((sel ? resp_valid_b : resp_valid_a) == 1'b0) && n < 50) begin
            tick();
            n++;
        end
        check(sel ? "latency_b" : "latency_a", 32'(cyc - acc_cyc), 32'(lat));
    endtask

    task automatic do_req(input bit sel, input logic we, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp);
        send_req(sel, we, addr, be, wdata, exp, 1'b1);
        wait_resp(sel, sel ? 2 : 4);
        tick();
    endtask

    initial begin
        logic        r_we;
        logic [9:0]  r_addr;
        logic [3:0]  r_be;
        logic [31:0] r_wdata;
        logic [31:0] r_exp;
        int          n;

        rst         = 1'b1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_we      = 1'b0;
        req_addr    = 10'd0;
        req_be      = 4'd0;
        req_wdata   = 32'd0;
        resp_ready  = 1'b1;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;

        vecs[0]  = '{1'b1, 10'h005, 4'hF,    32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 10'h005, 4'h0,    32'h00000000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 10'h010, 4'hF,    32'h11223344, 32'h11223344};
        vecs[3]  = '{1'b1, 10'h010, 4'b0101, 32'hAABBCCDD, 32'h11BB33DD};
        vecs[4]  = '{1'b0, 10'h010, 4'h0,    32'h00000000, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 10'h010, 4'b0000, 32'hFFFFFFFF, 32'h11BB33DD};
        vecs[6]  = '{1'b0, 10'h010, 4'h0,    32'h00000000, 32'h11BB33DD};
        vecs[7]  = '{1'b1, 10'h3FF, 4'hF,    32'h12345678, 32'h12345678};
        vecs[8]  = '{1'b0, 10'h3FF, 4'h0,    32'h00000000, 32'h12345678};
        vecs[9]  = '{1'b1, 10'h005, 4'b1010, 32'h99887766, 32'h99AD77EF};
        vecs[10] = '{1'b0, 10'h005, 4'h0,    32'h00000000, 32'h99AD77EF};

        // Reset values and registered req_ready
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready_a), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_rdata", resp_rdata_a, 32'd0);
        check("rst_req_ready_b", 32'(req_ready_b), 32'd0);
        rst = 1'b0;
        tick();
        check("release_req_ready", 32'(req_ready_a), 32'd1);
        check("release_req_ready_b", 32'(req_ready_b), 32'd1);

        // Table-driven loads and stores
        for (int i = 0; i < 11; i++) begin
            do_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].rdata);
        end

        // Backpressure in RESP
        resp_ready = 1'b0;
        send_req(1'b0, 1'b0, 10'h010, 4'h0, 32'd0, 32'h11BB33DD, 1'b1);
        wait_resp(1'b0, 4);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(resp_valid_a), 32'd1);
            check("bp_rdata", resp_rdata_a, 32'h11BB33DD);
            check("bp_req_ready", 32'(req_ready_a), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        check("bp_ready_hold", 32'(req_ready_a), 32'd0);
        tick();
        check("bp_req_ready_after", 32'(req_ready_a), 32'd1);
        check("bp_valid_drop", 32'(resp_valid_a), 32'd0);

        // Reset during WAIT drops the store
        send_req(1'b0, 1'b1, 10'h3FF, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0);
        check("rst_wait_state", 32'(state_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait_busy", 32'(busy_a), 32'd0);
        check("rst_wait_valid", 32'(resp_valid_a), 32'd0);
        check("rst_wait_ready", 32'(req_ready_a), 32'd0);
        tick();
        check("rst_wait_ready_after", 32'(req_ready_a), 32'd1);
        repeat (6) tick();
        do_req(1'b0, 1'b0, 10'h3FF, 4'h0, 32'd0, 32'h12345678);

        // Reset on the ACCESS edge wins over the write
        send_req(1'b0, 1'b1, 10'h010, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b0);
        n = 0;
        while (state_a != 2'd2 && n < 10) begin
            tick();
            n++;
        end
        check("rst_acc_state", 32'(state_a), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_acc_busy", 32'(busy_a), 32'd0);
        check("rst_acc_valid", 32'(resp_valid_a), 32'd0);
        tick();
        do_req(1'b0, 1'b0, 10'h010, 4'h0, 32'd0, 32'h11BB33DD);

        // Random traffic over a small colliding address window
        for (int i = 0; i < 8; i++) begin
            r_wdata = $urandom;
            do_req(1'b0, 1'b1, 10'(32'h20 + i), 4'hF, r_wdata, r_wdata);
        end
        for (int i = 0; i < 16; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 10'(32'h20 + $urandom_range(0, 7));
            r_be    = 4'($urandom_range(0, 15));
            r_wdata = $urandom;
            r_exp   = model_mem[r_addr];
            for (int b = 0; b < 4; b++) begin
                if (r_we && r_be[b]) r_exp[8*b +: 8] = r_wdata[8*b +: 8];
            end
            do_req(1'b0, r_we, r_addr, r_be, r_wdata, r_exp);
        end

        // Zero-wait build: 2-cycle latency, 3 cycles per transaction
        do_req(1'b1, 1'b1, 10'h003, 4'hF, 32'h0BADF00D, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 1'b0, 10'h003, 4'h0, 32'd0, 32'h0BADF00D);
            check("throughput_b", 32'(acc_cyc - prev_acc), 32'd3);
        end

        repeat (3) tick();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exp0_q_empty", 32'(exp0_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
